// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared defaults, state encoding and sizing helpers for the
//               byte-wide SPI master with loopback slave.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_WIDTH = 8;
    localparam int c_DIV_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Divider counter width: the largest divide select (2^DIV_W - 1) needs a
    // terminal count of 2^(2^DIV_W - 1) - 1, i.e. that many bits.
    function automatic int cnt_width(input int div_w);
        return (1 << div_w) - 1;
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_if
// Description : Host bus plus SPI/debug visibility signals of the SPI master.
//               'master' is the host side, 'slave' is the SPI block side.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 2
) ();

    logic             cs;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] in_data;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] out_data;
    logic             mosi;
    logic             miso;
    logic             sclk;
    logic [WIDTH-1:0] mastershift;
    logic [WIDTH-1:0] slaveshift;

    modport master (
        output cs, wr, rd, in_data, div,
        input  out_data, mosi, miso, sclk, mastershift, slaveshift
    );

    modport slave (
        input  cs, wr, rd, in_data, div,
        output out_data, mosi, miso, sclk, mastershift, slaveshift
    );

endinterface : spi_master_if
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : SPI clock generator. Latches the divide select on start, then
//               toggles sclk every 2^div clk cycles, flags each rising toggle
//               and signals done on the falling toggle after WIDTH rises.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int DIV_W = c_DIV_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [DIV_W-1:0] div,
    output logic                  sclk,
    output logic                  rise_pulse,
    output logic                  done
);

    localparam int c_CNT_W = cnt_width(DIV_W);
    localparam int c_BIT_W = $clog2(WIDTH + 1);

    logic               r_run;
    logic               r_sclk;
    logic [DIV_W-1:0]   r_div;
    logic [c_CNT_W-1:0] r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;

    logic [c_CNT_W-1:0] w_term;
    logic               w_tick;
    logic               w_rise;
    logic               w_last;

    // Terminal count 2^div - 1 (low r_div bits set), and toggle qualifiers.
    always_comb begin
        w_term = ~({c_CNT_W{1'b1}} << r_div);
        w_tick = r_run && (r_div_cnt == w_term);
        w_rise = w_tick && !r_sclk;
        w_last = w_tick && r_sclk && (r_bit_cnt == c_BIT_W'(WIDTH));
    end

    // Divider counter, bit counter and sclk toggle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run     <= 1'b0;
            r_sclk    <= 1'b0;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (r_run) begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_sclk    <= ~r_sclk;
                if (w_rise) begin
                    r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
                if (w_last) begin
                    r_run <= 1'b0;
                end
            end else begin
                r_div_cnt <= r_div_cnt + c_CNT_W'(1);
            end
        end else if (start) begin
            r_run     <= 1'b1;
            r_sclk    <= 1'b0;
            r_div     <= div;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
        end
    end

    assign sclk       = r_sclk;
    assign rise_pulse = w_rise;
    assign done       = w_last;

endmodule : spi_sclk_gen
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Byte-wide SPI master (mode 0, MSB first) with a loopback
//               slave shift register. A host write starts a full-duplex
//               exchange; a host read captures the master shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int DIV_W = c_DIV_W
) (
    input  wire logic   clk,
    input  wire logic   rst,
    spi_master_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_mastershift;
    logic [WIDTH-1:0] r_slaveshift;

    logic             w_start;
    logic             w_rise;
    logic             w_done;
    logic             w_sclk;
    logic             w_mosi;
    logic             w_miso;

    // Serial lines come straight from the register MSBs so the first bit is
    // on the wire before the first sclk rise.
    assign w_mosi  = r_mastershift[WIDTH-1];
    assign w_miso  = r_slaveshift[WIDTH-1];
    assign w_start = (r_state == IDLE) && bus.cs && bus.wr;

    spi_sclk_gen #(
        .WIDTH (WIDTH),
        .DIV_W (DIV_W)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .div        (bus.div),
        .sclk       (w_sclk),
        .rise_pulse (w_rise),
        .done       (w_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a write starts a transfer, the generator ends it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = XFER;
            XFER:    if (w_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Host read capture, write load and the full-duplex shift on sclk rises.
    // A read in the same cycle as a load sees the pre-load value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data    <= '0;
            r_mastershift <= '0;
            r_slaveshift  <= '0;
        end else begin
            if (bus.cs && bus.rd) begin
                r_out_data <= r_mastershift;
            end
            if (w_start) begin
                r_mastershift <= bus.in_data;
            end else if (w_rise) begin
                r_mastershift <= {r_mastershift[WIDTH-2:0], w_miso};
                r_slaveshift  <= {r_slaveshift[WIDTH-2:0], w_mosi};
            end
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.mosi        = w_mosi;
    assign bus.miso        = w_miso;
    assign bus.sclk        = w_sclk;
    assign bus.mastershift = r_mastershift;
    assign bus.slaveshift  = r_slaveshift;

endmodule : spi_master
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Directed self-checking bench for spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    spi_master_if #(.WIDTH(8), .DIV_W(2)) bus ();

    spi_master #(.WIDTH(8), .DIV_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cs = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    // Start a transfer and watch it until sclk settles low after 8 rises.
    // Optionally injects one host strobe (with different data/div) at tick inj_at.
    task automatic run_xfer(input logic [7:0] data, input logic [1:0] dv,
                            input bit start_rd, input int inj_at,
                            input bit inj_wr, input bit inj_rd,
                            output int cycles, output logic [7:0] mseq,
                            output int bad);
        int   since;
        int   rises;
        bit   fin;
        logic prev_sclk;
        logic prev_mosi;
        bus.div     = dv;
        bus.in_data = data;
        bus.cs      = 1'b1;
        bus.wr      = 1'b1;
        bus.rd      = start_rd;
        tick();
        idle_inputs();
        since = 0; rises = 0; bad = 0; mseq = '0; cycles = -1; fin = 1'b0;
        prev_sclk = bus.sclk;
        prev_mosi = bus.mosi;
        for (int i = 1; i <= 2000 && !fin; i++) begin
            if (i == inj_at) begin
                bus.cs      = 1'b1;
                bus.wr      = inj_wr;
                bus.rd      = inj_rd;
                bus.in_data = 8'hFF;
                bus.div     = 2'd0;
            end
            tick();
            idle_inputs();
            since++;
            if (bus.sclk !== prev_sclk) begin
                if (since != (1 << dv)) bad++;
                since = 0;
                if (bus.sclk === 1'b1) begin
                    mseq = {mseq[6:0], prev_mosi};
                    rises++;
                end else if (rises == 8) begin
                    cycles = i;
                    fin    = 1'b1;
                end
            end
            prev_sclk = bus.sclk;
            prev_mosi = bus.mosi;
        end
        bus.div = dv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.in_data = 8'h00;
        bus.div     = 2'd0;
        tick();
        tick();
        n_total++;
        if ({bus.out_data, bus.mastershift, bus.slaveshift} !== 24'h0)
            $display("FAIL reset_regs: got %h/%h/%h expected 00/00/00",
                     bus.out_data, bus.mastershift, bus.slaveshift);
        else n_pass++;
        n_total++;
        if ({bus.sclk, bus.mosi, bus.miso} !== 3'b000)
            $display("FAIL reset_lines: got sclk/mosi/miso=%b expected 000",
                     {bus.sclk, bus.mosi, bus.miso});
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_xfer();
        int cyc; int bad; logic [7:0] seq;
        run_xfer(8'hCA, 2'd0, 1'b0, 0, 1'b0, 1'b0, cyc, seq, bad);
        n_total++;
        if (cyc != 16) $display("FAIL xfer1_cycles: got %0d expected 16", cyc);
        else n_pass++;
        n_total++;
        if (seq !== 8'hCA || bad != 0)
            $display("FAIL xfer1_mosi: got seq %h bad %0d expected CA 0", seq, bad);
        else n_pass++;
        n_total++;
        if ({bus.mastershift, bus.slaveshift, bus.sclk} !== {8'h00, 8'hCA, 1'b0})
            $display("FAIL xfer1_result: got ms %h ss %h sclk %b expected 00 CA 0",
                     bus.mastershift, bus.slaveshift, bus.sclk);
        else n_pass++;
    endtask

    task automatic test_second_xfer();
        int cyc; int bad; logic [7:0] seq;
        run_xfer(8'h51, 2'd0, 1'b0, 0, 1'b0, 1'b0, cyc, seq, bad);
        n_total++;
        if ({bus.mastershift, bus.slaveshift} !== {8'hCA, 8'h51} || cyc != 16)
            $display("FAIL xfer2_result: got ms %h ss %h cyc %0d expected CA 51 16",
                     bus.mastershift, bus.slaveshift, cyc);
        else n_pass++;
    endtask

    task automatic test_read();
        int tog;
        bus.cs = 1'b1;
        bus.rd = 1'b1;
        tick();
        idle_inputs();
        n_total++;
        if (bus.out_data !== 8'hCA)
            $display("FAIL read_data: got %h expected CA", bus.out_data);
        else n_pass++;
        tog = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.sclk !== 1'b0) tog++;
        end
        n_total++;
        if ({bus.mastershift, bus.slaveshift} !== {8'hCA, 8'h51} || tog != 0)
            $display("FAIL read_quiet: got ms %h ss %h sclk-high %0d expected CA 51 0",
                     bus.mastershift, bus.slaveshift, tog);
        else n_pass++;
    endtask

    task automatic test_third_xfer();
        int cyc; int bad; logic [7:0] seq;
        run_xfer(8'h51, 2'd0, 1'b0, 0, 1'b0, 1'b0, cyc, seq, bad);
        n_total++;
        if ({bus.mastershift, bus.slaveshift, bus.out_data} !== {8'h51, 8'h51, 8'hCA})
            $display("FAIL xfer3_result: got ms %h ss %h out %h expected 51 51 CA",
                     bus.mastershift, bus.slaveshift, bus.out_data);
        else n_pass++;
    endtask

    task automatic test_wr_rd_same_cycle();
        int cyc; int bad; logic [7:0] seq;
        run_xfer(8'h0F, 2'd0, 1'b1, 0, 1'b0, 1'b0, cyc, seq, bad);
        n_total++;
        if (bus.out_data !== 8'h51)
            $display("FAIL wrrd_preload_read: got %h expected 51", bus.out_data);
        else n_pass++;
        n_total++;
        if ({bus.mastershift, bus.slaveshift} !== {8'h51, 8'h0F} || seq !== 8'h0F)
            $display("FAIL wrrd_result: got ms %h ss %h seq %h expected 51 0F 0F",
                     bus.mastershift, bus.slaveshift, seq);
        else n_pass++;
    endtask

    task automatic test_div3();
        int cyc; int bad; logic [7:0] seq;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_xfer(8'hA5, 2'd3, 1'b0, 20, 1'b1, 1'b0, cyc, seq, bad);
        n_total++;
        if (cyc != 128) $display("FAIL div3_cycles: got %0d expected 128", cyc);
        else n_pass++;
        n_total++;
        if (bad != 0) $display("FAIL div3_halfperiod: got %0d bad intervals expected 0", bad);
        else n_pass++;
        n_total++;
        if ({bus.mastershift, bus.slaveshift} !== {8'h00, 8'hA5} || seq !== 8'hA5)
            $display("FAIL div3_result: got ms %h ss %h seq %h expected 00 A5 A5",
                     bus.mastershift, bus.slaveshift, seq);
        else n_pass++;
    endtask

    task automatic test_rd_during_xfer();
        int cyc; int bad; logic [7:0] seq;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_xfer(8'hF0, 2'd0, 1'b0, 5, 1'b0, 1'b1, cyc, seq, bad);
        n_total++;
        if (bus.out_data !== 8'hC0)
            $display("FAIL rd_partial: got %h expected C0", bus.out_data);
        else n_pass++;
        n_total++;
        if ({bus.mastershift, bus.slaveshift} !== {8'h00, 8'hF0} || cyc != 16)
            $display("FAIL rd_xfer_result: got ms %h ss %h cyc %0d expected 00 F0 16",
                     bus.mastershift, bus.slaveshift, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int tog;
        bus.div     = 2'd0;
        bus.in_data = 8'hA5;
        bus.cs      = 1'b1;
        bus.wr      = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        n_total++;
        if ({bus.out_data, bus.mastershift, bus.slaveshift, bus.sclk} !== 25'h0)
            $display("FAIL rst_mid: got out %h ms %h ss %h sclk %b expected all 0",
                     bus.out_data, bus.mastershift, bus.slaveshift, bus.sclk);
        else n_pass++;
        rst = 1'b0;
        tog = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.sclk !== 1'b0) tog++;
        end
        n_total++;
        if (tog != 0) $display("FAIL rst_mid_idle: got %0d sclk-high cycles expected 0", tog);
        else n_pass++;
        bus.in_data = 8'h77;
        bus.wr      = 1'b1;
        bus.rd      = 1'b1;
        tick();
        idle_inputs();
        tog = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.sclk !== 1'b0) tog++;
        end
        n_total++;
        if ({bus.mastershift, bus.out_data} !== 16'h0 || tog != 0)
            $display("FAIL no_cs_ignored: got ms %h out %h sclk-high %0d expected 00 00 0",
                     bus.mastershift, bus.out_data, tog);
        else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        bus.cs      = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.in_data = 8'h00;
        bus.div     = 2'd0;
        test_reset();
        test_first_xfer();
        test_second_xfer();
        test_read();
        test_third_xfer();
        test_wr_rd_same_cycle();
        test_div3();
        test_rd_during_xfer();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_spi_master
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Byte-wide SPI master (mode 0, MSB first) with a built-in loopback slave shift register, used as a self-contained SPI lab/demo block.
- A host write loads a byte and starts an 8-bit full-duplex exchange between the master and slave shift registers over mosi/miso.
- A host read latches the master's received byte onto out_data.
- Both shift registers are exported for debug/visibility.

Parameters:
- WIDTH, 8, transfer/shift-register width in bits.
- DIV_W, 2, width of the clock-divider select input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- out_data  output  WIDTH  last byte read from the master shift register.
- mosi  output  1  master serial out; equals mastershift[WIDTH-1].
- miso  output  1  slave serial out, looped back into the master; equals slaveshift[WIDTH-1].
- sclk  output  1  SPI serial clock; idle low.
- mastershift  output  WIDTH  master shift register contents.
- slaveshift  output  WIDTH  internal slave shift register contents.
- cs  input  1  host chip-select; qualifies wr/rd.
- wr  input  1  host write strobe; load in_data and start a transfer.
- rd  input  1  host read strobe; capture mastershift into out_data.
- in_data  input  WIDTH  byte to transmit.
- div  input  DIV_W  sclk divider select; sclk half-period = 2^div clk cycles.

Behaviour:
- Reset (rst=1 at a clk edge): out_data, mastershift, slaveshift = 0; sclk = 0; busy = 0; divider and bit counters = 0. Reset mid-transfer aborts the transfer immediately; no partial result is kept.
- States: IDLE, XFER.
- IDLE:
  - cs & wr: mastershift <= in_data; latch div; clear counters; go to XFER (busy from next cycle).
  - cs & rd: out_data <= mastershift (1-cycle latency).
  - If wr and rd are both set with cs, both actions happen. The read captures the pre-load mastershift value.
  - Without cs, wr and rd are ignored.
- XFER:
  - Divider counter counts clk cycles. When it reaches 2^div_latched - 1, sclk toggles and the counter clears.
  - On each sclk rising toggle (0->1), simultaneously: mastershift <= {mastershift[WIDTH-2:0], miso}; slaveshift <= {slaveshift[WIDTH-2:0], mosi}.
  - Falling toggles only change sclk.
  - After WIDTH rising edges, the following falling toggle returns sclk to 0 and the state returns to IDLE.
  - Transfer duration is exactly 2*WIDTH*2^div clk cycles (div=0: 16 cycles).
- wr during XFER is ignored (no reload, no restart). rd during XFER is honoured and returns the current, partially shifted mastershift.
- Net effect of one transfer: mastershift and slaveshift exchange contents.
- div changes during XFER have no effect; the latched value is used.
- mosi and miso are combinational from the register MSBs, so mosi is valid before the first sclk rising edge (mode 0).
- slaveshift changes only by shifting and by reset.

Decomposition:
- Package spi_pkg: WIDTH/DIV_W defaults and the state enum {IDLE, XFER}.
- One sub-module, spi_sclk_gen:
  - Inputs: clk, rst, start, div.
  - Outputs: sclk, rise_pulse, done.
  - Contents: divider counter, bit counter, sclk toggle logic.
- Shift registers and host interface stay in spi_master.

Test Plan:
- Reset, div=0. Pulse cs/wr for 1 cycle with in_data=0xCA. Expect: sclk shows 8 pulses over 16 cycles; mosi sequence 1,1,0,0,1,0,1,0; at end mastershift=0x00, slaveshift=0xCA, sclk=0.
- Next, pulse cs/wr with in_data=0x51. Expect at end: mastershift=0xCA, slaveshift=0x51.
- Pulse cs/rd. Expect: out_data=0xCA one cycle later; shift registers unchanged; no sclk activity.
- Pulse cs/wr with 0x51. Expect at end: mastershift=0x51, slaveshift=0x51; out_data still 0xCA.
- div=3, write 0xA5 from reset. Expect: sclk half-period of 8 cycles and a 128-cycle transfer. A second wr mid-transfer is ignored; final slaveshift=0xA5.
- Assert rst mid-transfer. Expect: all outputs 0 on the next edge and IDLE. wr without cs does nothing.
